kbd_rx: RTL

KBD_RX -- requirements
Module: kbd_rx

---
 rtl/kbd_pkg.sv | 27 ++
 rtl/kbd_fifo.sv | 63 ++++++
 rtl/kbd_rx.sv | 118 +++++++++++
 3 files changed

// File: rtl/kbd_pkg.sv
// kbd_pkg: shared definitions for the PS/2 keyboard receiver.
//   - default FIFO depth and frame timeout
//   - frame receiver state encodings
//   - frame accumulator record and odd-parity helper
package kbd_pkg;

    localparam int KBD_FIFO_DEPTH     = 8;
    localparam int KBD_TIMEOUT_CYCLES = 5000;   // 100 us at 50 MHz

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    // Partial frame being assembled by the receiver.
    typedef struct packed {
        logic [7:0] shift;      // data bits, LSB arrives first
        logic [2:0] bit_cnt;    // data bits received so far
        logic       parity_ok;  // result of the parity check
    } rx_frame_t;

    // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] b, input logic p);
        return ^{b, p};
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// kbd_fifo: byte FIFO between the PS/2 frame receiver and the MMIO read port.
// Ports:
//   clk, rst        system clock, async active-high reset
//   push, push_data write strobe and byte from the receiver
//   pop             read strobe; ignored when empty
//   empty, full     occupancy flags
//   head            oldest byte, 8'h00 when empty
//   overflow        sticky: a byte was dropped because the FIFO was full
module kbd_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic       empty,
    output logic       full,
    output logic [7:0] head,
    output logic       overflow
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          do_push, do_pop;

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign head  = empty ? 8'h00 : mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // accepted when a pop accompanies it. A pop on empty is always dropped.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push & ~do_push) overflow <= 1'b1;
        end
    end

    // Storage is not reset; count guards every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/kbd_rx.sv
// kbd_rx: PS/2 keyboard receiver with a byte FIFO.
// Synchronizes the raw PS/2 lines, decodes 11-bit frames (start, 8 data
// LSB-first, odd parity, stop) on ps2_clk falling edges and queues good bytes.
// Ports:
//   clk, rst            system clock, async active-high reset
//   ps2_clk, ps2_data   raw PS/2 lines, asynchronous to clk
//   read_enable         one-cycle pop strobe per byte consumed
//   ready               FIFO non-empty
//   overflow            sticky: a good byte was dropped on a full FIFO
//   data                FIFO head byte, 8'h00 when empty
module kbd_rx
    import kbd_pkg::*;
#(
    parameter int FIFO_DEPTH     = KBD_FIFO_DEPTH,
    parameter int TIMEOUT_CYCLES = KBD_TIMEOUT_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       read_enable,
    output logic       ready,
    output logic       overflow,
    output logic [7:0] data
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic        clk_s1, sync_clk, sync_clk_prev;
    logic        dat_s1, sync_dat;
    logic        fall;
    logic [1:0]  state;
    rx_frame_t   frm;
    logic [TW-1:0] idle_cnt;
    logic        timeout;
    logic        push;
    logic        fifo_empty, fifo_full;

    // Two-flop synchronizers plus an edge-history flop; all idle high so a
    // reset never manufactures a falling edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1        <= 1'b1;
            sync_clk      <= 1'b1;
            sync_clk_prev <= 1'b1;
            dat_s1        <= 1'b1;
            sync_dat      <= 1'b1;
        end else begin
            clk_s1        <= ps2_clk;
            sync_clk      <= clk_s1;
            sync_clk_prev <= sync_clk;
            dat_s1        <= ps2_data;
            sync_dat      <= dat_s1;
        end
    end

    assign fall = sync_clk_prev & ~sync_clk;

    // Fires on the TIMEOUT_CYCLES-th consecutive edgeless cycle of a frame.
    assign timeout = (state != ST_IDLE) && !fall &&
                     (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            frm      <= '0;
            idle_cnt <= '0;
        end else begin
            if (state == ST_IDLE || fall || timeout) idle_cnt <= '0;
            else                                     idle_cnt <= idle_cnt + 1'b1;

            if (timeout) begin
                state       <= ST_IDLE;
                frm.bit_cnt <= '0;
            end else if (fall) begin
                case (state)
                    ST_IDLE: begin
                        if (!sync_dat) begin
                            state       <= ST_DATA;
                            frm.bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        frm.shift   <= {sync_dat, frm.shift[7:1]};
                        frm.bit_cnt <= frm.bit_cnt + 1'b1;
                        if (frm.bit_cnt == 3'd7) state <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        frm.parity_ok <= odd_parity_ok(frm.shift, sync_dat);
                        state         <= ST_STOP;
                    end
                    default: begin
                        state       <= ST_IDLE;
                        frm.bit_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // Bad parity or a low stop bit drops the byte without any flag.
    assign push = fall && (state == ST_STOP) && frm.parity_ok && sync_dat;

    kbd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (frm.shift),
        .pop       (read_enable),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .head      (data),
        .overflow  (overflow)
    );

    assign ready = ~fifo_empty;

endmodule
